// File: rtl/uart_frame_tx.sv
// ---------------------------------------------------------------------------
// uart_frame_tx
//
// Transmit-side framer for the badge UART command protocol. A single-cycle
// `start` captures one command byte and a (FRAME_BYTES-2)-byte payload. The
// frame is then sent as 8N1 serial in this order: cmd, payload lane 0 ..
// lane FRAME_BYTES-3, cmd again as the end-character.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2)
//   FRAME_BYTES   total bytes per frame including both cmd bytes (3..32)
//
// Ports
//   clk       in   system clock
//   nreset    in   asynchronous active-low reset
//   start     in   frame request, sampled every cycle, ignored while busy
//   cmd       in   command byte (first and last byte of the frame)
//   payload   in   payload, lane i = payload[8i+7:8i] = frame byte i+1
//   busy      out  high while a frame is in flight
//   done      out  one-cycle pulse after the final stop bit
//   byte_idx  out  index of the byte on the line, 0 when idle
//   tx        out  serial line, idle high
//
// States
//   IDLE      | line high, waiting for start; done pulses here
//   START_BIT | line low for one bit time
//   DATA_BITS | eight data bits of the current byte, LSB first
//   STOP_BIT  | line high for one bit time, then next byte or IDLE
// ---------------------------------------------------------------------------
module uart_frame_tx #(
    parameter int CLKS_PER_BIT = 10752,
    parameter int FRAME_BYTES  = 18
) (
    input  logic                         clk,
    input  logic                         nreset,
    input  logic                         start,
    input  logic [7:0]                   cmd,
    input  logic [8*(FRAME_BYTES-2)-1:0] payload,
    output logic                         busy,
    output logic                         done,
    output logic [4:0]                   byte_idx,
    output logic                         tx
);

    localparam int PAYLOAD_W = 8 * (FRAME_BYTES - 2);
    localparam int BAUD_W    = $clog2(CLKS_PER_BIT);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [4:0]        LAST_IDX  = 5'(FRAME_BYTES - 1);
    localparam logic [2:0]        LAST_BIT  = 3'd7;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START_BIT = 2'd1,
        DATA_BITS = 2'd2,
        STOP_BIT  = 2'd3
    } state_t;

    state_t                state;
    logic [BAUD_W-1:0]     baud_cnt;
    logic [2:0]            bit_cnt;
    logic [7:0]            cmd_q;
    logic [PAYLOAD_W-1:0]  payload_q;
    logic [7:0]            cur_byte;
    logic [2:0]            next_bit;
    logic                  bit_end;

    // Byte currently being serialised. Both ends of the frame carry the
    // latched command; the interior indices walk the latched payload lanes.
    always_comb begin
        cur_byte = cmd_q;
        for (int k = 0; k < FRAME_BYTES - 2; k++) begin
            if (byte_idx == 5'(k + 1)) begin
                cur_byte = payload_q[8*k +: 8];
            end
        end
    end

    assign next_bit = bit_cnt + 3'd1;
    assign bit_end  = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            cmd_q     <= '0;
            payload_q <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            byte_idx  <= '0;
            tx        <= 1'b1;
        end else begin
            done <= 1'b0;

            case (state)
                IDLE: begin
                    tx       <= 1'b1;
                    busy     <= 1'b0;
                    byte_idx <= '0;
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    // The cycle that shows done is spent here, so a start
                    // held high launches the next frame straight away.
                    if (start) begin
                        cmd_q     <= cmd;
                        payload_q <= payload;
                        busy      <= 1'b1;
                        tx        <= 1'b0;
                        state     <= START_BIT;
                    end
                end

                START_BIT: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx       <= cur_byte[0];
                        state    <= DATA_BITS;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                DATA_BITS: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == LAST_BIT) begin
                            tx    <= 1'b1;
                            state <= STOP_BIT;
                        end else begin
                            bit_cnt <= next_bit;
                            tx      <= cur_byte[next_bit];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                STOP_BIT: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        if (byte_idx < LAST_IDX) begin
                            // Next start bit follows the stop bit directly.
                            byte_idx <= byte_idx + 5'd1;
                            tx       <= 1'b0;
                            state    <= START_BIT;
                        end else begin
                            byte_idx <= '0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            tx       <= 1'b1;
                            state    <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_tx.sv
module tb_uart_frame_tx;

    localparam int CPB = 4;
    localparam int FB  = 18;
    localparam int PW  = 8 * (FB - 2);

    logic          clk     = 1'b0;
    logic          nreset  = 1'b0;
    logic          start   = 1'b0;
    logic [7:0]    cmd     = 8'h00;
    logic [PW-1:0] payload = '0;
    logic          busy;
    logic          done;
    logic [4:0]    byte_idx;
    logic          tx;

    uart_frame_tx #(.CLKS_PER_BIT(CPB), .FRAME_BYTES(FB)) dut (
        .clk      (clk),
        .nreset   (nreset),
        .start    (start),
        .cmd      (cmd),
        .payload  (payload),
        .busy     (busy),
        .done     (done),
        .byte_idx (byte_idx),
        .tx       (tx)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int   cyc = 0;
    int   fall_cnt = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   done_busy_err = 0;
    logic prev_tx = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        prev_tx <= tx;
        if (prev_tx === 1'b1 && tx === 1'b0) fall_cnt <= fall_cnt + 1;
        if (done === 1'b1) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
            if (busy !== 1'b0) done_busy_err <= done_busy_err + 1;
        end
    end

    logic [7:0] rx_bytes  [FB];
    logic [7:0] exp_bytes [FB];
    bit         rx_timeout;
    bit         rx_frame_ok;
    int         rx_fall_cyc;

    // Bench receiver: locks onto the first low sample, then samples every bit
    // at a fixed offset, so any gap between bytes corrupts the result.
    task automatic rx_frame();
        int t;
        logic [7:0] v;
        t = 0;
        rx_timeout  = 1'b0;
        rx_frame_ok = 1'b1;
        while (tx !== 1'b0) begin
            if (t >= 3000) begin
                rx_timeout = 1'b1;
                return;
            end
            @(negedge clk);
            t++;
        end
        rx_fall_cyc = cyc;
        for (int b = 0; b < FB; b++) begin
            @(negedge clk);
            if (tx !== 1'b0) rx_frame_ok = 1'b0;
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                v[i] = tx;
            end
            repeat (CPB) @(negedge clk);
            if (tx !== 1'b1) rx_frame_ok = 1'b0;
            rx_bytes[b] = v;
            if (b < FB - 1) repeat (CPB - 1) @(negedge clk);
        end
    endtask

    function automatic void fill_exp(input logic [7:0] c, input logic [PW-1:0] p);
        for (int k = 0; k < FB; k++) begin
            if (k == 0 || k == FB - 1) exp_bytes[k] = c;
            else                       exp_bytes[k] = p[8*(k-1) +: 8];
        end
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        #12;
        total++; if (tx !== 1'b1)        begin bad++; $display("FAIL reset_tx: got %b want 1", tx); end
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0)      begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (byte_idx !== 5'd0)  begin bad++; $display("FAIL reset_byte_idx: got %0d want 0", byte_idx); end
        @(negedge clk);
        nreset = 1'b1;
        repeat (5) @(negedge clk);
        total++; if (tx !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL idle_after_reset: tx=%b busy=%b want tx=1 busy=0", tx, busy);
        end
    endtask

    task automatic test_basic();
        int base;
        base = done_cnt;
        cmd = 8'h40;
        payload = '0;
        payload[7:0] = 8'h41;
        fill_exp(cmd, payload);
        pulse_start();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b want 1", busy); end
        rx_frame();
        total++; if (rx_timeout) begin bad++; $display("FAIL basic_timeout: got no start bit want frame"); end
        total++; if (!rx_frame_ok) begin bad++; $display("FAIL basic_framing: got bad start/stop want 0/1"); end
        for (int k = 0; k < FB; k++) begin
            total++;
            if (rx_bytes[k] !== exp_bytes[k]) begin
                bad++; $display("FAIL basic_byte%0d: got %h want %h", k, rx_bytes[k], exp_bytes[k]);
            end
        end
        repeat (8) @(negedge clk);
        total++; if (done_cnt !== base + 1) begin bad++; $display("FAIL basic_done_count: got %0d want %0d", done_cnt - base, 1); end
        total++; if (done_cyc - rx_fall_cyc !== FB * 10 * CPB) begin
            bad++; $display("FAIL basic_done_latency: got %0d want %0d", done_cyc - rx_fall_cyc, FB * 10 * CPB);
        end
        total++; if (busy !== 1'b0 || byte_idx !== 5'd0 || tx !== 1'b1) begin
            bad++; $display("FAIL basic_idle: busy=%b idx=%0d tx=%b want 0 0 1", busy, byte_idx, tx);
        end
    endtask

    task automatic test_aes();
        string s;
        s = "0123456789abcdef";
        cmd = 8'h42;
        for (int i = 0; i < FB - 2; i++) payload[8*i +: 8] = s[i];
        fill_exp(cmd, payload);
        pulse_start();
        rx_frame();
        total++; if (rx_timeout || !rx_frame_ok) begin
            bad++; $display("FAIL aes_framing: got timeout=%0d ok=%0d want 0 1", rx_timeout, rx_frame_ok);
        end
        total++; if (rx_bytes[0] !== 8'h42 || rx_bytes[FB-1] !== 8'h42) begin
            bad++; $display("FAIL aes_cmd_ends: got %h/%h want 42/42", rx_bytes[0], rx_bytes[FB-1]);
        end
        for (int k = 1; k < FB - 1; k++) begin
            total++;
            if (rx_bytes[k] !== exp_bytes[k]) begin
                bad++; $display("FAIL aes_byte%0d: got %h want %h", k, rx_bytes[k], exp_bytes[k]);
            end
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_busy_ignore();
        int  base;
        int  fc;
        bit  reached;
        base = done_cnt;
        reached = 1'b0;
        cmd = 8'h43;
        for (int i = 0; i < FB - 2; i++) payload[8*i +: 8] = 8'(8'h10 + i);
        fill_exp(cmd, payload);
        pulse_start();
        fork
            rx_frame();
            begin
                int t;
                t = 0;
                while (byte_idx !== 5'd5 && t < 2000) begin @(negedge clk); t++; end
                if (byte_idx === 5'd5) begin
                    reached = 1'b1;
                    cmd = 8'h44;
                    start = 1'b1;
                    repeat (3) @(negedge clk);
                    start = 1'b0;
                end
            end
        join
        total++; if (!reached) begin bad++; $display("FAIL busy_reach_idx5: got not reached want reached"); end
        total++; if (rx_timeout || !rx_frame_ok) begin
            bad++; $display("FAIL busy_framing: got timeout=%0d ok=%0d want 0 1", rx_timeout, rx_frame_ok);
        end
        for (int k = 0; k < FB; k++) begin
            total++;
            if (rx_bytes[k] !== exp_bytes[k]) begin
                bad++; $display("FAIL busy_byte%0d: got %h want %h", k, rx_bytes[k], exp_bytes[k]);
            end
        end
        @(negedge clk);
        fc = fall_cnt;
        repeat (60) @(negedge clk);
        total++; if (fall_cnt !== fc) begin bad++; $display("FAIL busy_no_second_frame: got %0d falls want 0", fall_cnt - fc); end
        total++; if (done_cnt !== base + 1) begin bad++; $display("FAIL busy_done_count: got %0d want 1", done_cnt - base); end
    endtask

    task automatic test_back_to_back();
        int base;
        int d1;
        bit got_done;
        base = done_cnt;
        d1 = 0;
        got_done = 1'b0;
        cmd = 8'h61;
        for (int i = 0; i < FB - 2; i++) payload[8*i +: 8] = 8'(8'hA0 + i);
        fill_exp(cmd, payload);
        start = 1'b1;
        @(negedge clk);
        fork
            begin
                for (int f = 0; f < 2; f++) begin
                    rx_frame();
                    total++; if (rx_timeout || !rx_frame_ok) begin
                        bad++; $display("FAIL b2b_framing%0d: got timeout=%0d ok=%0d want 0 1", f, rx_timeout, rx_frame_ok);
                    end
                    for (int k = 0; k < FB; k++) begin
                        total++;
                        if (rx_bytes[k] !== exp_bytes[k]) begin
                            bad++; $display("FAIL b2b_f%0d_byte%0d: got %h want %h", f, k, rx_bytes[k], exp_bytes[k]);
                        end
                    end
                end
            end
            begin
                int t;
                t = 0;
                while (done_cnt == base && t < 3000) begin @(negedge clk); t++; end
                got_done = (done_cnt != base);
                d1 = done_cyc;
                start = 1'b0;
            end
        join
        start = 1'b0;
        total++; if (!got_done) begin bad++; $display("FAIL b2b_first_done: got none want pulse"); end
        // Second start bit must begin on the edge right after done.
        total++; if (rx_fall_cyc !== d1 + 1) begin
            bad++; $display("FAIL b2b_gap: got fall at done+%0d want done+1", rx_fall_cyc - d1);
        end
        repeat (40) @(negedge clk);
        total++; if (done_cnt !== base + 2) begin bad++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt - base); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        int base;
        int fc;
        int t;
        base = done_cnt;
        cmd = 8'h52;
        for (int i = 0; i < FB - 2; i++) payload[8*i +: 8] = 8'(8'h30 ^ (i * 7));
        pulse_start();
        t = 0;
        while (byte_idx !== 5'd7 && t < 2000) begin @(negedge clk); t++; end
        total++; if (byte_idx !== 5'd7) begin bad++; $display("FAIL rst_reach_idx7: got %0d want 7", byte_idx); end
        // start bit (4) + bits 0..2 (12) puts bit 3 at offsets 16..19
        repeat (17) @(negedge clk);
        #1 nreset = 1'b0;
        #1;
        total++; if (tx !== 1'b1)       begin bad++; $display("FAIL rst_mid_tx: got %b want 1", tx); end
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        total++; if (byte_idx !== 5'd0) begin bad++; $display("FAIL rst_mid_idx: got %0d want 0", byte_idx); end
        repeat (3) @(negedge clk);
        nreset = 1'b1;
        fc = fall_cnt;
        repeat (50) @(negedge clk);
        total++; if (fall_cnt !== fc || tx !== 1'b1) begin
            bad++; $display("FAIL rst_no_resume: got %0d falls tx=%b want 0 falls tx=1", fall_cnt - fc, tx);
        end
        total++; if (done_cnt !== base) begin bad++; $display("FAIL rst_no_done: got %0d pulses want 0", done_cnt - base); end
        cmd = 8'h53;
        fill_exp(cmd, payload);
        pulse_start();
        rx_frame();
        total++; if (rx_timeout || !rx_frame_ok) begin
            bad++; $display("FAIL rst_new_framing: got timeout=%0d ok=%0d want 0 1", rx_timeout, rx_frame_ok);
        end
        for (int k = 0; k < FB; k++) begin
            total++;
            if (rx_bytes[k] !== exp_bytes[k]) begin
                bad++; $display("FAIL rst_new_byte%0d: got %h want %h", k, rx_bytes[k], exp_bytes[k]);
            end
        end
        repeat (8) @(negedge clk);
        total++; if (done_cnt !== base + 1) begin bad++; $display("FAIL rst_new_done: got %0d want 1", done_cnt - base); end
    endtask

    task automatic test_stability();
        cmd = 8'h5A;
        for (int i = 0; i < FB - 2; i++) payload[8*i +: 8] = 8'(8'hC3 + 5 * i);
        fill_exp(cmd, payload);
        pulse_start();
        fork
            rx_frame();
            begin
                int t;
                t = 0;
                while (t < 2000) begin
                    if (busy !== 1'b1) break;
                    cmd = 8'($urandom);
                    payload = {$urandom, $urandom, $urandom, $urandom};
                    @(negedge clk);
                    t++;
                end
            end
        join
        total++; if (rx_timeout || !rx_frame_ok) begin
            bad++; $display("FAIL stab_framing: got timeout=%0d ok=%0d want 0 1", rx_timeout, rx_frame_ok);
        end
        for (int k = 0; k < FB; k++) begin
            total++;
            if (rx_bytes[k] !== exp_bytes[k]) begin
                bad++; $display("FAIL stab_byte%0d: got %h want %h", k, rx_bytes[k], exp_bytes[k]);
            end
        end
        repeat (8) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_aes();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_stability();
        total++; if (done_busy_err !== 0) begin
            bad++; $display("FAIL done_with_busy: got %0d cycles want 0", done_busy_err);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
